// File: rtl/wb_regfile_scoreboard.sv
// Writeback end of the pipeline: architectural register file with
// same-cycle WB bypass, plus per-register in-flight write counters for ID.
module wb_regfile_scoreboard #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int AW   = 5,
   parameter int CNTW = 2
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            issue_valid,
   input  logic            issue_wr,
   input  logic [AW-1:0]   issue_rd,
   output logic            issue_ready,
   input  logic            flush,
   input  logic            wb_RFWr,
   input  logic [AW-1:0]   wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic [AW-1:0]   rs1_addr,
   input  logic [AW-1:0]   rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic            rs1_busy,
   output logic            rs2_busy,
   output logic            err_underflow
);

   localparam logic [CNTW-1:0] CNT_MAX = '1;

   logic [XLEN-1:0] regs_q [NREG];
   logic [CNTW-1:0] cnt_q  [NREG];
   logic [CNTW-1:0] cnt_d  [NREG];
   logic            err_q, err_d;
   logic            wb_en, inc, dec;

   assign wb_en = wb_RFWr && (wb_rd != '0);

   // The stall looks only at the current count, so a same-cycle retire never
   // reaches the ready path.
   assign issue_ready = !(issue_valid && issue_wr && (issue_rd != '0) &&
                          (cnt_q[issue_rd] == CNT_MAX));
   assign inc = issue_valid && issue_wr && issue_ready && (issue_rd != '0);
   assign dec = wb_en && (cnt_q[wb_rd] != '0);

   // Retire with nothing pending; a WB landing in the flush cycle is exempt.
   assign err_d = wb_en && (cnt_q[wb_rd] == '0) && !flush;

   function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
      logic [XLEN-1:0] data;
      data = '0;
      if (addr == '0)                      data = '0;
      else if (wb_RFWr && (wb_rd == addr)) data = wb_data;
      else                                 data = regs_q[addr];
      return data;
   endfunction

   // The final retiring write is served by the bypass, so it no longer stalls.
   function automatic logic busy_of(input logic [AW-1:0] addr);
      return (addr != '0) && (cnt_q[addr] != '0) &&
             !(dec && (wb_rd == addr) && (cnt_q[addr] == CNTW'(1)));
   endfunction

   assign rs1_data      = read_port(rs1_addr);
   assign rs2_data      = read_port(rs2_addr);
   assign rs1_busy      = busy_of(rs1_addr);
   assign rs2_busy      = busy_of(rs2_addr);
   assign err_underflow = err_q;

   // NOTE: every cnt_d entry is assigned a default before any condition, so
   // this block can never infer a latch.
   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         cnt_d[i] = cnt_q[i];
         if (flush) begin
            cnt_d[i] = '0;
         end else begin
            if (inc && (issue_rd == AW'(i)) && !(dec && (wb_rd == AW'(i))))
               cnt_d[i] = cnt_q[i] + CNTW'(1);
            else if (dec && (wb_rd == AW'(i)) && !(inc && (issue_rd == AW'(i))))
               cnt_d[i] = cnt_q[i] - CNTW'(1);
         end
      end
   end

   // NOTE: the register file must clear on reset, so it is built from flops
   // with a reset loop rather than left as an uninitialised RAM.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
         err_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every read in this block on
         // the pre-edge values, matching the combinational next-state logic.
         if (wb_en) regs_q[wb_rd] <= wb_data;
         for (int i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
         err_q <= err_d;
      end
   end

endmodule
